// File: rtl/vga_copper_if.sv
// Register-port bus of the tinyqv VGA peripheral: address, write data and
// write size (data_write_n == 2'b11 means no write this cycle).
interface vga_copper_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;

  // The side that drives a write onto the bus.
  modport master (
    output address,
    output data_in,
    output data_write_n
  );

  // The side that receives the write.
  modport slave (
    input address,
    input data_in,
    input data_write_n
  );
endinterface

// File: rtl/vga_copper.sv
// Scanline-synchronised register-write sequencer ("copper") for the tinyqv
// VGA peripheral. Replays a list of (scanline, register, data) writes every
// frame and shares the peripheral register port with the CPU. The CPU always
// has priority; a blocked copper write simply retries on the next cycle.
module vga_copper #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          list_we,
  input  logic [AW-1:0] list_waddr,
  input  logic [31:0]   list_wdata,
  input  logic [AW:0]   list_len,
  input  logic [9:0]    vga_y,
  input  logic          vga_frame_start,
  vga_copper_if.slave   cpu,
  vga_copper_if.master  per,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT_Y = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          overrun_q, overrun_d;
  logic [9:0]    cur_y_q;
  logic [5:0]    cur_addr_q;
  logic [15:0]   cur_data_q;
  logic [31:0]   mem_q [DEPTH];

  logic [AW:0]   len_c;
  logic [AW:0]   idx_inc;
  logic          accept;

  // Lengths beyond the list size run the whole list once.
  assign len_c   = (list_len > DEPTH_W) ? DEPTH_W : list_len;
  assign idx_inc = (AW+1)'(idx_q) + (AW+1)'(1);
  assign overrun = overrun_q;

  // List memory: written at any time, never reset.
  always_ff @(posedge clk) begin
    if (list_we) begin
      mem_q[list_waddr] <= list_wdata;
    end
  end

  // Latch the current entry during FETCH so later list writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_y_q    <= '0;
      cur_addr_q <= '0;
      cur_data_q <= '0;
    end else if (state_q == FETCH) begin
      cur_y_q    <= mem_q[idx_q][31:22];
      cur_addr_q <= mem_q[idx_q][21:16];
      cur_data_q <= mem_q[idx_q][15:0];
    end
  end

  // State register with list index and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic: sequence through the list, restart on a new frame,
  // and drop back to IDLE whenever the copper is disabled.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE, DONE: begin
        if (vga_frame_start) begin
          idx_d   = '0;
          state_d = (len_c != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        state_d = WAIT_Y;
      end
      WAIT_Y: begin
        // Entries whose scanline has already passed fire straight away.
        if (vga_y >= cur_y_q) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          idx_d   = idx_inc[AW-1:0];
          // >= rather than == so a list shortened mid-frame still terminates.
          state_d = (idx_inc >= len_c) ? DONE : FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // A new frame before the list finished: flag it and start over.
    if (vga_frame_start && busy) begin
      overrun_d = 1'b1;
      idx_d     = '0;
      state_d   = (len_c != '0) ? FETCH : DONE;
    end

    if (!enable) begin
      state_d   = IDLE;
      idx_d     = '0;
      overrun_d = 1'b0;
    end
  end

  // Output logic: busy flag and the CPU/copper mux onto the peripheral port.
  always_comb begin
    busy   = (state_q == FETCH) || (state_q == WAIT_Y) || (state_q == ISSUE);
    // The copper only gets the port in a cycle the CPU leaves idle; reset and
    // disable both suppress it immediately.
    accept = (state_q == ISSUE) && enable && rst_n && (cpu.data_write_n == 2'b11);

    per.address      = cpu.address;
    per.data_in      = cpu.data_in;
    per.data_write_n = cpu.data_write_n;
    if (accept) begin
      per.address      = cur_addr_q;
      per.data_in      = {16'd0, cur_data_q};
      per.data_write_n = 2'b01;
    end
  end

endmodule

// File: tb/tb_vga_copper.sv
// Directed bench for vga_copper: expected peripheral writes are queued as the
// stimulus is driven and popped whenever the DUT shows a write on its port.
module tb_vga_copper;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
    logic [1:0]  w;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          list_we;
  logic [AW-1:0] list_waddr;
  logic [31:0]   list_wdata;
  logic [AW:0]   list_len;
  logic [9:0]    vga_y;
  logic          vga_frame_start;
  logic          busy;
  logic          overrun;

  vga_copper_if cpu_if ();
  vga_copper_if per_if ();

  vga_copper #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .list_we         (list_we),
    .list_waddr      (list_waddr),
    .list_wdata      (list_wdata),
    .list_len        (list_len),
    .vga_y           (vga_y),
    .vga_frame_start (vga_frame_start),
    .cpu             (cpu_if),
    .per             (per_if),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  wr_t  exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   n_writes = 0;
  logic [1:0] obs_wn;
  logic obs_busy;
  logic obs_overrun;
  logic seen_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample the port mid-cycle, score any write, then move to
  // just after the next rising edge where the caller changes inputs.
  task automatic cyc();
    wr_t e;
    wr_t got;
    @(negedge clk);
    obs_wn      = per_if.data_write_n;
    obs_busy    = busy;
    obs_overrun = overrun;
    if (obs_wn !== 2'b11) begin
      n_writes++;
      got = '{a: per_if.address, d: per_if.data_in, w: per_if.data_write_n};
      checks++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected: observed write %0h expected none", got);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_write", 64'(got), 64'(e));
      end
      $display("write addr=%0h data=%0h wn=%b", got.a, got.d, got.w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int i, input logic [9:0] y, input logic [5:0] a,
                             input logic [15:0] d);
    list_we    = 1'b1;
    list_waddr = AW'(i);
    list_wdata = {y, a, d};
    cyc();
    list_we    = 1'b0;
  endtask

  task automatic frame();
    vga_frame_start = 1'b1;
    cyc();
    vga_frame_start = 1'b0;
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    exp_q.push_back('{a: a, d: d, w: w});
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; list_we = 1'b0; list_waddr = '0; list_wdata = '0;
    list_len = '0; vga_y = '0; vga_frame_start = 1'b0;
    cpu_if.address = '0; cpu_if.data_in = '0; cpu_if.data_write_n = 2'b11;
    @(posedge clk); #1;
    cyc(); cyc();
    check("rst_busy", 64'(obs_busy), 64'(0));
    check("rst_overrun", 64'(obs_overrun), 64'(0));
    check("rst_wn", 64'(obs_wn), 64'(2'b11));
    rst_n = 1'b1;

    // Basic two-entry list.
    write_entry(0, 10'd0, 6'h30, 16'h0B10);
    write_entry(1, 10'd100, 6'h31, 16'h003F);
    enable = 1'b1; list_len = 4'd2; vga_y = 10'd0;
    cyc();
    push(6'h30, 32'h0000_0B10, 2'b01);
    frame();
    cyc(); check("t1_fetch_nowrite", 64'(obs_wn), 64'(2'b11));
    cyc(); check("t1_waity_nowrite", 64'(obs_wn), 64'(2'b11));
    check("t1_busy", 64'(obs_busy), 64'(1));
    cyc(); check("t1_latency", 64'(obs_wn), 64'(2'b01));
    cyc(); cyc(); cyc();
    vga_y = 10'd99; cyc(); cyc();
    push(6'h31, 32'h0000_003F, 2'b01);
    vga_y = 10'd100;
    cyc(); cyc(); check("t1_y100", 64'(obs_wn), 64'(2'b01));
    cyc(); check("t1_done_busy", 64'(obs_busy), 64'(0));
    check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

    // CPU write collides with the copper's ISSUE cycle.
    list_len = 4'd1; vga_y = 10'd0;
    push(6'h34, 32'd20, 2'b00);
    push(6'h30, 32'h0000_0B10, 2'b01);
    frame(); cyc(); cyc();
    cpu_if.address = 6'h34; cpu_if.data_in = 32'd20; cpu_if.data_write_n = 2'b00;
    cyc(); check("t2_cpu_pass", 64'(obs_wn), 64'(2'b00));
    cpu_if.data_write_n = 2'b11;
    cyc(); check("t2_copper_retry", 64'(obs_wn), 64'(2'b01));
    cyc(); check("t2_done_busy", 64'(obs_busy), 64'(0));
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

    // Overrun: entry 2 waits for a scanline that never comes.
    write_entry(2, 10'd700, 6'h32, 16'h1234);
    list_len = 4'd3; vga_y = 10'd0;
    push(6'h30, 32'h0000_0B10, 2'b01);
    frame(); cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
    push(6'h31, 32'h0000_003F, 2'b01);
    vga_y = 10'd100; cyc(); cyc();
    vga_y = 10'd525; cyc(); cyc(); cyc(); cyc();
    check("t3_busy_before", 64'(obs_busy), 64'(1));
    check("t3_overrun_before", 64'(obs_overrun), 64'(0));
    vga_y = 10'd0;
    push(6'h30, 32'h0000_0B10, 2'b01);
    frame();
    cyc(); check("t3_overrun", 64'(obs_overrun), 64'(1));
    cyc(); cyc(); check("t3_restart", 64'(obs_wn), 64'(2'b01));
    enable = 1'b0; cyc(); cyc();
    check("t3_overrun_clr", 64'(obs_overrun), 64'(0));
    check("t3_idle_busy", 64'(obs_busy), 64'(0));
    check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

    // Late entry fires as soon as it is waited on.
    write_entry(0, 10'd50, 6'h33, 16'h0055);
    enable = 1'b1; list_len = 4'd1; vga_y = 10'd200;
    push(6'h33, 32'h0000_0055, 2'b01);
    frame(); cyc();
    cyc(); check("t4_waity", 64'(obs_wn), 64'(2'b11));
    cyc(); check("t4_late", 64'(obs_wn), 64'(2'b01));
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));

    // Length clamping and empty list.
    for (int i = 0; i < DEPTH; i++) begin
      write_entry(i, 10'd0, 6'(6'h10 + i), 16'(16'hA000 + i));
      push(6'(6'h10 + i), 32'(16'hA000 + i), 2'b01);
    end
    list_len = 4'd15; vga_y = 10'd0; n_writes = 0;
    frame();
    repeat (30) cyc();
    check("t5_clamp_writes", 64'(n_writes), 64'(DEPTH));
    check("t5_done_busy", 64'(obs_busy), 64'(0));
    check("t5_queue_empty", 64'(exp_q.size()), 64'(0));
    list_len = 4'd0; n_writes = 0; seen_busy = 1'b0;
    frame();
    for (int i = 0; i < 10; i++) begin
      cyc();
      seen_busy = seen_busy | obs_busy;
    end
    check("t5_len0_writes", 64'(n_writes), 64'(0));
    check("t5_len0_busy", 64'(seen_busy), 64'(0));

    // Reset during ISSUE suppresses the copper write in that very cycle.
    write_entry(0, 10'd0, 6'h30, 16'h0B10);
    list_len = 4'd1; vga_y = 10'd0;
    frame(); cyc(); cyc();
    rst_n = 1'b0;
    cyc(); check("t6_rst_issue_wn", 64'(obs_wn), 64'(2'b11));
    rst_n = 1'b1;
    cyc(); check("t6_rst_issue_busy", 64'(obs_busy), 64'(0));

    // Reset during WAIT_Y; nothing more until the next frame.
    write_entry(0, 10'd700, 6'h35, 16'h0777);
    frame(); cyc(); cyc(); cyc();
    check("t6_waity_busy", 64'(obs_busy), 64'(1));
    rst_n = 1'b0; vga_y = 10'd800;
    cyc(); check("t6_rst_wn", 64'(obs_wn), 64'(2'b11));
    rst_n = 1'b1; n_writes = 0;
    cyc(); check("t6_rst_busy", 64'(obs_busy), 64'(0));
    repeat (8) cyc();
    check("t6_no_write_after_rst", 64'(n_writes), 64'(0));
    push(6'h35, 32'h0000_0777, 2'b01);
    frame(); cyc(); cyc();
    cyc(); check("t6_after_frame", 64'(obs_wn), 64'(2'b01));
    check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
